// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: byte width, default baud multiplier and the
// receive-handshake FSM state encoding used by uart_rx_fifo.
package uart_defs_pkg;

   localparam int DATA_W    = 8;
   localparam int BAUD_MULT = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } rx_state_t;

endpackage : uart_defs_pkg

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array: synchronous write port, asynchronous
// read port. Contents are not reset; occupancy tracking lives in the owner.
module uart_fifo_mem #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Store the incoming byte at the write address.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Receive buffer between the UART receiver and user logic.
// Acknowledges the receiver with a four-phase valid/ready handshake (one byte
// per handshake) and offers a first-word-fall-through read port.
// Optional build macro UART_RX_FIFO_DROP_EN: bytes arriving while full are
// acknowledged and discarded, and the sticky o_overflow output is added.
// Without it, a full FIFO back-pressures the receiver by withholding ready.
module uart_rx_fifo
   import uart_defs_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  i_uart_clk,
   input  logic                  i_rst,
   input  logic [DATA_W-1:0]     i_rx_byte,
   input  logic                  i_rx_valid,
   output logic                  o_rx_ready,
   output logic [DATA_W-1:0]     o_rd_data,
   output logic                  o_rd_valid,
   input  logic                  i_rd_en,
   output logic [DEPTH_LOG2:0]   o_count,
`ifdef UART_RX_FIFO_DROP_EN
   output logic                  o_overflow,
`endif
   output logic                  o_full
);

   localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   rx_state_t             state_q;
   logic                  rx_ready_q;
   logic [DEPTH_LOG2-1:0] wr_ptr_q;
   logic [DEPTH_LOG2-1:0] rd_ptr_q;
   logic [DEPTH_LOG2:0]   count_q;
   logic [DEPTH_LOG2:0]   count_d;
   logic [DATA_W-1:0]     rd_word;
   logic                  full;
   logic                  not_empty;
   logic                  accept;
   logic                  do_wr;
   logic                  do_pop;
`ifdef UART_RX_FIFO_DROP_EN
   logic                  overflow_q;
`endif

   // Decode write/pop for this cycle from the pre-edge flags and form next count.
   always_comb begin
      full      = (count_q == FULL_CNT);
      not_empty = (count_q != '0);
      accept    = (state_q == ST_IDLE) && i_rx_valid;
      do_wr     = accept && !full;
      do_pop    = i_rd_en && not_empty;
      count_d   = count_q;
      if (do_wr && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (!do_wr && do_pop) begin
         count_d = count_q - 1'b1;
      end
   end

   // Handshake FSM with registered ready (and sticky overflow when dropping).
   always_ff @(posedge i_uart_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         rx_ready_q <= 1'b0;
`ifdef UART_RX_FIFO_DROP_EN
         overflow_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
`ifdef UART_RX_FIFO_DROP_EN
               if (accept) begin
                  state_q    <= ST_ACK;
                  rx_ready_q <= 1'b1;
                  if (full) begin
                     overflow_q <= 1'b1;
                  end
               end
`else
               if (accept && !full) begin
                  state_q    <= ST_ACK;
                  rx_ready_q <= 1'b1;
               end
`endif
            end
            ST_ACK: begin
               if (!i_rx_valid) begin
                  state_q    <= ST_IDLE;
                  rx_ready_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               rx_ready_q <= 1'b0;
            end
         endcase
      end
   end

   // Pointers wrap modulo depth; occupancy is kept in its own counter.
   always_ff @(posedge i_uart_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
      end
   end

   uart_fifo_mem #(
      .ADDR_W (DEPTH_LOG2),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk       (i_uart_clk),
      .wr_en_i   (do_wr),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (i_rx_byte),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (rd_word)
   );

   // Head byte is forced to zero while empty so stale storage never shows.
   assign o_rd_data  = not_empty ? rd_word : '0;
   assign o_rd_valid = not_empty;
   assign o_rx_ready = rx_ready_q;
   assign o_count    = count_q;
   assign o_full     = full;
`ifdef UART_RX_FIFO_DROP_EN
   assign o_overflow = overflow_q;
`endif

endmodule : uart_rx_fifo
